// File: rtl/urv_writeback.sv
// Writeback stage: selects the result source, extracts load data from the AHB-Lite
// data phase, tracks wait states and bus errors, and drives the register-file write port.
// Optional registered forward path enabled by the URV_WB_BYPASS_EN macro; without it the
// w_bypass_* outputs are tied low and no bypass flops exist.
module urv_writeback (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [2:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_shifter_rd_i,
  input  logic [31:0] x_multiply_rd_i,
  input  logic [31:0] x_dm_addr_i,

  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,

  input  logic        w_stall_i,
  output logic        w_stall_req_o,

  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,

  output logic        w_bus_error_o,
  output logic [31:0] w_bus_err_addr_o,

  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_value_o,
  output logic        w_bypass_valid_o
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        mem_op;
  logic [31:0] byte_shift;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] src_value;

  assign mem_op = x_valid_i & (x_load_i | x_store_i);

  // Lane selection for sub-word loads; address low bits pick the byte/halfword lane.
  assign byte_shift = HRDATA >> {x_dm_addr_i[1:0], 3'b000};
  assign load_byte  = byte_shift[7:0];
  assign load_half  = x_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];

  // Load data extraction by funct3.
  always_comb begin
    load_data = 32'h0;
    case (x_fun_i)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      3'b010:  load_data = HRDATA;
      default: load_data = 32'h0;
    endcase
  end

  // Result source select; a valid load overrides every other source.
  always_comb begin
    src_value = x_rd_value_i;
    case (x_rd_source_i)
      3'd1:    src_value = x_shifter_rd_i;
      3'd2:    src_value = x_multiply_rd_i;
      default: src_value = x_rd_value_i;
    endcase
    if (x_valid_i && x_load_i) begin
      src_value = load_data;
    end
  end

  // Bus-phase FSM next state and error capture.
  always_comb begin
    state_d    = state_q;
    bus_err_d  = 1'b0;
    err_addr_d = err_addr_q;
    case (state_q)
      StIdle: begin
        if (mem_op && !HREADY) begin
          state_d = HRESP ? StErr : StWait;
        end
      end
      StWait: begin
        if (!mem_op || HREADY) begin
          state_d = StIdle;
        end else if (HRESP) begin
          state_d = StErr;
        end
      end
      StErr: begin
        // Error slot lasts one cycle; the faulting address is still presented here.
        state_d    = StIdle;
        bus_err_d  = 1'b1;
        err_addr_d = x_dm_addr_i;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and error registers; a global stall freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (!w_stall_i) begin
      state_q    <= state_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Stall while the data phase is pending or during the error slot.
  assign w_stall_req_o = (mem_op & ~HREADY) | (state_q == StErr);

  assign rf_rd_o       = x_rd_i;
  assign rf_rd_value_o = src_value;
  assign rf_rd_write_o = x_valid_i & x_rd_write_i & (x_rd_i != 5'd0) & ~x_store_i &
                         ~w_stall_req_o & ~w_stall_i;

  assign w_bus_error_o    = bus_err_q;
  assign w_bus_err_addr_o = err_addr_q;

`ifdef URV_WB_BYPASS_EN
  logic [4:0]  byp_rd_q;
  logic [31:0] byp_value_q;
  logic        byp_valid_q;

  // One-cycle-delayed copy of the register-file write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_rd_q    <= 5'd0;
      byp_value_q <= 32'h0;
      byp_valid_q <= 1'b0;
    end else if (!w_stall_i) begin
      byp_rd_q    <= rf_rd_o;
      byp_value_q <= rf_rd_value_o;
      byp_valid_q <= rf_rd_write_o;
    end
  end

  assign w_bypass_rd_o    = byp_rd_q;
  assign w_bypass_value_o = byp_value_q;
  assign w_bypass_valid_o = byp_valid_q;
`else
  assign w_bypass_rd_o    = 5'd0;
  assign w_bypass_value_o = 32'h0;
  assign w_bypass_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback: vector table, hand-written wait/error/stall/reset
// sequences, then randomized traffic against an access-level reference model.
module tb_urv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_valid_i, x_load_i, x_store_i, x_rd_write_i;
  logic [2:0]  x_fun_i, x_rd_source_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i, x_shifter_rd_i, x_multiply_rd_i, x_dm_addr_i;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, w_stall_i;
  logic        w_stall_req_o, rf_rd_write_o, w_bus_error_o, w_bypass_valid_o;
  logic [4:0]  rf_rd_o, w_bypass_rd_o;
  logic [31:0] rf_rd_value_o, w_bus_err_addr_o, w_bypass_value_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  urv_writeback dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_valid_i        (x_valid_i),
    .x_load_i         (x_load_i),
    .x_store_i        (x_store_i),
    .x_fun_i          (x_fun_i),
    .x_rd_i           (x_rd_i),
    .x_rd_write_i     (x_rd_write_i),
    .x_rd_source_i    (x_rd_source_i),
    .x_rd_value_i     (x_rd_value_i),
    .x_shifter_rd_i   (x_shifter_rd_i),
    .x_multiply_rd_i  (x_multiply_rd_i),
    .x_dm_addr_i      (x_dm_addr_i),
    .HRDATA           (HRDATA),
    .HREADY           (HREADY),
    .HRESP            (HRESP),
    .w_stall_i        (w_stall_i),
    .w_stall_req_o    (w_stall_req_o),
    .rf_rd_o          (rf_rd_o),
    .rf_rd_value_o    (rf_rd_value_o),
    .rf_rd_write_o    (rf_rd_write_o),
    .w_bus_error_o    (w_bus_error_o),
    .w_bus_err_addr_o (w_bus_err_addr_o),
    .w_bypass_rd_o    (w_bypass_rd_o),
    .w_bypass_value_o (w_bypass_value_o),
    .w_bypass_valid_o (w_bypass_valid_o)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  fun;
    logic [4:0]  rd;
    logic [2:0]  src;
    logic [31:0] opnd;
    logic [31:0] addr;
    logic [31:0] hrdata;
    logic [31:0] exp_val;
    logic        exp_wr;
  } vec_t;

  function automatic vec_t mk(logic ld, logic st, logic [2:0] fun, logic [4:0] rd,
                              logic [2:0] src, logic [31:0] opnd, logic [31:0] addr,
                              logic [31:0] hrdata, logic [31:0] exp_val, logic exp_wr);
    vec_t v;
    v.ld = ld; v.st = st; v.fun = fun; v.rd = rd; v.src = src; v.opnd = opnd;
    v.addr = addr; v.hrdata = hrdata; v.exp_val = exp_val; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    x_valid_i = 0; x_load_i = 0; x_store_i = 0; x_fun_i = 0; x_rd_i = 0;
    x_rd_write_i = 0; x_rd_source_i = 0; x_rd_value_i = 0; x_shifter_rd_i = 0;
    x_multiply_rd_i = 0; x_dm_addr_i = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    w_stall_i = 0;
  endtask

  // Word load to rd=9 presented on the data phase.
  task automatic load_op(input logic [31:0] addr, input logic hready, input logic hresp);
    x_valid_i = 1; x_load_i = 1; x_store_i = 0; x_fun_i = 3'b010; x_rd_i = 5'd9;
    x_rd_write_i = 1; x_rd_source_i = 0; x_dm_addr_i = addr; HRDATA = 32'h600D_F00D;
    HREADY = hready; HRESP = hresp;
  endtask

  // Reference load extraction from plain arithmetic on the lane value.
  function automatic logic [31:0] ref_load(logic [2:0] fun, logic [31:0] addr,
                                           logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * addr[1:0])) & 32'hFF;
    h = (d >> (16 * addr[1])) & 32'hFFFF;
    case (fun)
      3'b000:  return b - ((b & 32'h80) << 1);
      3'b100:  return b;
      3'b001:  return h - ((h & 32'h8000) << 1);
      3'b101:  return h;
      3'b010:  return d;
      default: return 32'h0;
    endcase
  endfunction

  vec_t tbl[14];

  // Model state: whether this cycle is the error slot, plus the registered outputs.
  logic        m_err, m_pulse;
  logic [31:0] m_eaddr;
  logic        m_bv;
  logic [4:0]  m_brd;
  logic [31:0] m_bval;

  initial begin
    set_idle();
    rst_i = 1;

    tbl[0]  = mk(1, 0, 3'b000,  5, 0, 32'h0,        32'h2, 32'h00F4_0000, 32'hFFFF_FFF4, 1);
    tbl[1]  = mk(1, 0, 3'b101,  6, 0, 32'h0,        32'h2, 32'h8001_1234, 32'h0000_8001, 1);
    tbl[2]  = mk(1, 0, 3'b100,  7, 0, 32'h0,        32'h1, 32'h1234_8056, 32'h0000_0080, 1);
    tbl[3]  = mk(1, 0, 3'b001,  8, 1, 32'h0,        32'h0, 32'h1234_F00D, 32'hFFFF_F00D, 1);
    tbl[4]  = mk(1, 0, 3'b010,  9, 2, 32'h0,        32'h4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    tbl[5]  = mk(1, 0, 3'b011, 10, 0, 32'h0,        32'h0, 32'hFFFF_FFFF, 32'h0,         1);
    tbl[6]  = mk(0, 0, 3'b000,  0, 0, 32'h5,        32'h0, 32'h0,         32'h5,         0);
    tbl[7]  = mk(0, 0, 3'b000,  7, 2, 32'h11,       32'h0, 32'h0,         32'h12,        1);
    tbl[8]  = mk(0, 0, 3'b000,  3, 1, 32'h0F0F_0000, 32'h0, 32'h0,        32'hF0F0_FFFF, 1);
    tbl[9]  = mk(0, 1, 3'b010,  4, 0, 32'hABCD,     32'h8, 32'h0,         32'hABCD,      0);
    tbl[10] = mk(1, 0, 3'b000, 11, 0, 32'h0,        32'h3, 32'h7F00_0000, 32'h0000_007F, 1);
    tbl[11] = mk(0, 0, 3'b000, 12, 7, 32'h77,       32'h0, 32'h0,         32'h77,        1);
    tbl[12] = mk(1, 0, 3'b001, 13, 0, 32'h0,        32'h2, 32'hC0DE_0000, 32'hFFFF_C0DE, 1);
    tbl[13] = mk(1, 0, 3'b110, 14, 0, 32'h0,        32'h0, 32'h1234_5678, 32'h0,         1);

    // Reset state
    tick(); tick();
    #4;
    chk("rst_err",      {31'h0, w_bus_error_o},    32'h0);
    chk("rst_eaddr",    w_bus_err_addr_o,          32'h0);
    chk("rst_byp_v",    {31'h0, w_bypass_valid_o}, 32'h0);
    chk("rst_byp_rd",   {27'h0, w_bypass_rd_o},    32'h0);
    chk("rst_byp_val",  w_bypass_value_o,          32'h0);
    chk("rst_stall",    {31'h0, w_stall_req_o},    32'h0);
    tick();
    rst_i = 0;

    // Single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      set_idle();
      x_valid_i = 1; x_load_i = tbl[i].ld; x_store_i = tbl[i].st; x_fun_i = tbl[i].fun;
      x_rd_i = tbl[i].rd; x_rd_write_i = 1; x_rd_source_i = tbl[i].src;
      x_rd_value_i = tbl[i].opnd; x_shifter_rd_i = ~tbl[i].opnd;
      x_multiply_rd_i = tbl[i].opnd + 32'h1; x_dm_addr_i = tbl[i].addr;
      HRDATA = tbl[i].hrdata;
      #4;
      chk($sformatf("vec%0d_val", i),   rf_rd_value_o,           tbl[i].exp_val);
      chk($sformatf("vec%0d_wr", i),    {31'h0, rf_rd_write_o},  {31'h0, tbl[i].exp_wr});
      chk($sformatf("vec%0d_rd", i),    {27'h0, rf_rd_o},        {27'h0, tbl[i].rd});
      chk($sformatf("vec%0d_stall", i), {31'h0, w_stall_req_o},  32'h0);
      tick();
    end

    // Bypass: write rd=3 with 32'hCAFE, observe next cycle
    set_idle();
    x_valid_i = 1; x_rd_write_i = 1; x_rd_i = 5'd3; x_rd_value_i = 32'hCAFE;
    tick();
    set_idle();
    #4;
`ifdef URV_WB_BYPASS_EN
    chk("byp_valid", {31'h0, w_bypass_valid_o}, 32'h1);
    chk("byp_rd",    {27'h0, w_bypass_rd_o},    32'h3);
    chk("byp_value", w_bypass_value_o,          32'hCAFE);
`else
    chk("byp_valid", {31'h0, w_bypass_valid_o}, 32'h0);
    chk("byp_rd",    {27'h0, w_bypass_rd_o},    32'h0);
    chk("byp_value", w_bypass_value_o,          32'h0);
`endif
    tick();

    // Three wait states, then completion on the 4th cycle
    for (int i = 0; i < 3; i++) begin
      load_op(32'h100, 0, 0);
      #4;
      chk($sformatf("wait%0d_stall", i), {31'h0, w_stall_req_o}, 32'h1);
      chk($sformatf("wait%0d_wr", i),    {31'h0, rf_rd_write_o}, 32'h0);
      tick();
    end
    load_op(32'h100, 1, 0);
    #4;
    chk("wait_done_stall", {31'h0, w_stall_req_o}, 32'h0);
    chk("wait_done_wr",    {31'h0, rf_rd_write_o}, 32'h1);
    chk("wait_done_val",   rf_rd_value_o,          32'h600D_F00D);
    tick();
    set_idle();
    #4;
    chk("wait_after_wr", {31'h0, rf_rd_write_o}, 32'h0);
    tick();

    // Error straight from idle: HRESP/!HREADY, then HRESP/HREADY
    load_op(32'h1000_0004, 0, 1);
    #4;
    chk("err_a_stall", {31'h0, w_stall_req_o}, 32'h1);
    chk("err_a_wr",    {31'h0, rf_rd_write_o}, 32'h0);
    tick();
    load_op(32'h1000_0004, 1, 1);
    #4;
    chk("err_b_stall", {31'h0, w_stall_req_o}, 32'h1);
    chk("err_b_wr",    {31'h0, rf_rd_write_o}, 32'h0);
    chk("err_b_pulse", {31'h0, w_bus_error_o}, 32'h0);
    tick();
    set_idle();
    #4;
    chk("err_c_pulse", {31'h0, w_bus_error_o}, 32'h1);
    chk("err_c_addr",  w_bus_err_addr_o,       32'h1000_0004);
    tick();
    #4;
    chk("err_d_pulse", {31'h0, w_bus_error_o}, 32'h0);
    chk("err_d_addr",  w_bus_err_addr_o,       32'h1000_0004);
    tick();

    // Error raised after a wait state
    load_op(32'h2000_0008, 0, 0);
    tick();
    load_op(32'h2000_0008, 0, 1);
    #4;
    chk("werr_a_stall", {31'h0, w_stall_req_o}, 32'h1);
    tick();
    load_op(32'h2000_0008, 1, 0);
    #4;
    chk("werr_b_stall", {31'h0, w_stall_req_o}, 32'h1);
    chk("werr_b_wr",    {31'h0, rf_rd_write_o}, 32'h0);
    tick();
    set_idle();
    #4;
    chk("werr_c_pulse", {31'h0, w_bus_error_o}, 32'h1);
    chk("werr_c_addr",  w_bus_err_addr_o,       32'h2000_0008);
    tick();

    // Global stall freezes the FSM: an error response seen under stall is ignored
    load_op(32'h300, 0, 1);
    w_stall_i = 1;
    #4;
    chk("frz_a_wr", {31'h0, rf_rd_write_o}, 32'h0);
    tick();
    load_op(32'h300, 1, 0);
    w_stall_i = 0;
    #4;
    chk("frz_b_stall", {31'h0, w_stall_req_o}, 32'h0);
    chk("frz_b_wr",    {31'h0, rf_rd_write_o}, 32'h1);
    tick();
    set_idle();
    #4;
    chk("frz_c_pulse", {31'h0, w_bus_error_o}, 32'h0);
    tick();

    // Reset mid-WAIT abandons the access and clears the captured error address
    load_op(32'h400, 0, 0);
    tick();
    set_idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    #4;
    chk("rstw_stall", {31'h0, w_stall_req_o},    32'h0);
    chk("rstw_wr",    {31'h0, rf_rd_write_o},    32'h0);
    chk("rstw_pulse", {31'h0, w_bus_error_o},    32'h0);
    chk("rstw_addr",  w_bus_err_addr_o,          32'h0);
    chk("rstw_bypv",  {31'h0, w_bypass_valid_o}, 32'h0);
    chk("rstw_bypd",  w_bypass_value_o,          32'h0);
    tick();

    // Reset mid-ERR: no error pulse afterwards
    load_op(32'h500, 0, 1);
    tick();
    set_idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    #4;
    chk("rste_pulse", {31'h0, w_bus_error_o}, 32'h0);
    chk("rste_stall", {31'h0, w_stall_req_o}, 32'h0);
    tick();
    #4;
    chk("rste_pulse2", {31'h0, w_bus_error_o}, 32'h0);
    tick();

    // Randomized traffic against the access-level model, from a fresh reset
    set_idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    m_err = 0; m_pulse = 0; m_eaddr = 0; m_bv = 0; m_brd = 0; m_bval = 0;
    for (int n = 0; n < 400; n++) begin
      logic        mem, e_stall, e_wr;
      logic [31:0] e_val;
      logic [2:0]  kind;
      kind = 3'($urandom_range(0, 5));
      x_valid_i       = ($urandom_range(0, 3) != 0);
      x_load_i        = (kind < 3);
      x_store_i       = (kind == 3);
      x_fun_i         = 3'($urandom);
      x_rd_i          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      x_rd_write_i    = ($urandom_range(0, 4) != 0);
      x_rd_source_i   = 3'($urandom);
      x_rd_value_i    = $urandom;
      x_shifter_rd_i  = $urandom;
      x_multiply_rd_i = $urandom;
      x_dm_addr_i     = $urandom;
      HRDATA          = $urandom;
      HREADY          = ($urandom_range(0, 1) != 0);
      HRESP           = ($urandom_range(0, 3) == 0);
      w_stall_i       = ($urandom_range(0, 6) == 0);
      #4;
      mem     = x_valid_i && (x_load_i || x_store_i);
      e_stall = m_err || (mem && !HREADY);
      if (x_valid_i && x_load_i) e_val = ref_load(x_fun_i, x_dm_addr_i, HRDATA);
      else if (x_rd_source_i == 3'd1) e_val = x_shifter_rd_i;
      else if (x_rd_source_i == 3'd2) e_val = x_multiply_rd_i;
      else e_val = x_rd_value_i;
      e_wr = x_valid_i && x_rd_write_i && (x_rd_i != 0) && !x_store_i && !e_stall && !w_stall_i;
      chk("rnd_stall", {31'h0, w_stall_req_o}, {31'h0, e_stall});
      chk("rnd_wr",    {31'h0, rf_rd_write_o}, {31'h0, e_wr});
      chk("rnd_val",   rf_rd_value_o,          e_val);
      chk("rnd_pulse", {31'h0, w_bus_error_o}, {31'h0, m_pulse});
      chk("rnd_eaddr", w_bus_err_addr_o,       m_eaddr);
`ifdef URV_WB_BYPASS_EN
      chk("rnd_bypv", {31'h0, w_bypass_valid_o}, {31'h0, m_bv});
      chk("rnd_bypr", {27'h0, w_bypass_rd_o},    {27'h0, m_brd});
      chk("rnd_bypd", w_bypass_value_o,          m_bval);
`else
      chk("rnd_bypv", {31'h0, w_bypass_valid_o}, 32'h0);
`endif
      if (!w_stall_i) begin
        m_pulse = m_err;
        if (m_err) m_eaddr = x_dm_addr_i;
        m_err  = !m_err && mem && !HREADY && HRESP;
        m_bv   = e_wr;
        m_brd  = x_rd_i;
        m_bval = e_val;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
